// File: rtl/rds_msg_builder_if.sv
// RDS message RAM write bus: the builder is master, the message store is slave.
interface rds_msg_builder_if;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/rds_msg_builder.sv
// Builds RDS group 0A (PS name) bitstreams with CRC checkwords and writes them byte-wise to RAM.
// Optional feature: define RDS_PS_WRITE_EN to make the 8 PS characters runtime-writable.
module rds_msg_builder #(
  parameter logic [8:0]  c_base_addr  = 9'd0,
  parameter int unsigned c_repeat     = 5,
  parameter logic [63:0] c_ps_default = "RADIO   "
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       pi,
  input  logic [4:0]        pty,
  input  logic              tp,
  input  logic              ta,
  input  logic              ms,
  input  logic [3:0]        di,
  input  logic              ps_we,
  input  logic [2:0]        ps_addr,
  input  logic [7:0]        ps_data,
  rds_msg_builder_if.master wr,
  output logic              busy,
  output logic              done
);

  localparam logic [15:0] REP_LAST = 16'(c_repeat - 1);
  localparam logic [9:0]  POLY     = 10'h1B9;

  typedef enum logic [1:0] {S_IDLE, S_CRC, S_EMIT, S_DONE} state_t;

  typedef struct packed {
    logic [15:0] pi;
    logic [4:0]  pty;
    logic        tp;
    logic        ta;
    logic        ms;
    logic [3:0]  di;
    logic [63:0] ps;
  } snap_t;

  state_t      state_q, state_d;
  snap_t       snap_q, snap_d;
  logic [1:0]  blk_q, blk_d;
  logic [1:0]  seg_q, seg_d;
  logic [15:0] rep_q, rep_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [9:0]  crc_q, crc_d;
  logic [7:0]  acc_q, acc_d;
  logic        byte_rdy_q, byte_rdy_d;
  logic        wr_en_q, wr_en_d;
  logic [8:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [63:0] ps_cur;
  logic [15:0] ps_pair, blk_data;
  logic [9:0]  blk_off, chk;
  logic        data_bit, emit_bit, crc_fb;
  logic        last_crc, last_emit, last_blk;

`ifdef RDS_PS_WRITE_EN
  logic [7:0][7:0] ps_q, ps_d;

  // Writes land only while fully idle; an in-flight build reads its own snapshot.
  always_comb begin
    ps_d = ps_q;
    if (ps_we && state_q == S_IDLE && !busy_q)
      ps_d[3'd7 - ps_addr] = ps_data;
  end

  always_ff @(posedge clk) begin
    if (reset) ps_q <= c_ps_default;
    else       ps_q <= ps_d;
  end

  assign ps_cur = ps_q;
`else
  logic unused_ps;
  assign unused_ps = ^{ps_we, ps_addr, ps_data};
  assign ps_cur    = c_ps_default;
`endif

  // Block payload and offset for the current (segment, block)
  always_comb begin
    case (seg_q)
      2'd0:    ps_pair = snap_q.ps[63:48];
      2'd1:    ps_pair = snap_q.ps[47:32];
      2'd2:    ps_pair = snap_q.ps[31:16];
      default: ps_pair = snap_q.ps[15:0];
    endcase
    case (blk_q)
      2'd0: begin
        blk_data = snap_q.pi;
        blk_off  = 10'h0FC;
      end
      2'd1: begin
        blk_data = {5'b00000, snap_q.tp, snap_q.pty, snap_q.ta, snap_q.ms,
                    snap_q.di[2'd3 - seg_q], seg_q};
        blk_off  = 10'h198;
      end
      2'd2: begin
        blk_data = 16'hE0CD;
        blk_off  = 10'h168;
      end
      default: begin
        blk_data = ps_pair;
        blk_off  = 10'h1B4;
      end
    endcase
  end

  assign chk       = crc_q ^ blk_off;
  assign data_bit  = blk_data[4'd15 - cnt_q[3:0]];
  assign emit_bit  = cnt_q[4] ? chk[4'd9 - cnt_q[3:0]] : data_bit;
  assign crc_fb    = data_bit ^ crc_q[9];
  assign last_crc  = (cnt_q == 5'd15);
  assign last_emit = (cnt_q == 5'd25);
  assign last_blk  = (blk_q == 2'd3) && (seg_q == 2'd3) && (rep_q == REP_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CRC;
      S_CRC:   if (last_crc) state_d = S_EMIT;
      S_EMIT:  if (last_emit) state_d = last_blk ? S_DONE : S_CRC;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    snap_d     = snap_q;
    blk_d      = blk_q;
    seg_d      = seg_q;
    rep_d      = rep_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    crc_d      = crc_q;
    acc_d      = acc_q;
    byte_rdy_d = 1'b0;
    // A byte completed last cycle is presented now; the address steps after each write.
    wr_en_d    = byte_rdy_q;
    wr_data_d  = byte_rdy_q ? acc_q : wr_data_q;
    wr_addr_d  = wr_en_q ? wr_addr_q + 9'd1 : wr_addr_q;
    busy_d     = (state_q != S_IDLE);
    done_d     = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d.pi  = pi;
          snap_d.pty = pty;
          snap_d.tp  = tp;
          snap_d.ta  = ta;
          snap_d.ms  = ms;
          snap_d.di  = di;
          snap_d.ps  = ps_cur;
          blk_d      = 2'd0;
          seg_d      = 2'd0;
          rep_d      = 16'd0;
          cnt_d      = 5'd0;
          bit_d      = 3'd0;
          crc_d      = 10'd0;
          acc_d      = 8'd0;
          wr_addr_d  = c_base_addr;
        end
      end
      S_CRC: begin
        crc_d = {crc_q[8:0], 1'b0} ^ (crc_fb ? POLY : 10'h000);
        cnt_d = last_crc ? 5'd0 : cnt_q + 5'd1;
      end
      S_EMIT: begin
        acc_d = {acc_q[6:0], emit_bit};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) byte_rdy_d = 1'b1;
        if (last_emit) begin
          cnt_d = 5'd0;
          crc_d = 10'd0;
          blk_d = blk_q + 2'd1;
          if (blk_q == 2'd3) begin
            seg_d = seg_q + 2'd1;
            if (seg_q == 2'd3)
              rep_d = (rep_q == REP_LAST) ? 16'd0 : rep_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q     <= '0;
      blk_q      <= 2'd0;
      seg_q      <= 2'd0;
      rep_q      <= 16'd0;
      cnt_q      <= 5'd0;
      bit_q      <= 3'd0;
      crc_q      <= 10'd0;
      acc_q      <= 8'd0;
      byte_rdy_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= c_base_addr;
      wr_data_q  <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      snap_q     <= snap_d;
      blk_q      <= blk_d;
      seg_q      <= seg_d;
      rep_q      <= rep_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      crc_q      <= crc_d;
      acc_q      <= acc_d;
      byte_rdy_q <= byte_rdy_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = wr_addr_q;
  assign wr.wr_data = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_rds_msg_builder.sv
// Scoreboard bench for rds_msg_builder: expected RAM writes come from a polynomial-division model.
module tb_rds_msg_builder;
  localparam logic [8:0] BASE   = 9'd500;
  localparam int         R      = 5;
  localparam int         NB     = 52 * R;
  localparam int         DONE_E = 672 * R + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pi = '0;
  logic [4:0]  pty = '0;
  logic        tp = 1'b0, ta = 1'b0, ms = 1'b0;
  logic [3:0]  di = '0;
  logic        ps_we = 1'b0;
  logic [2:0]  ps_addr = '0;
  logic [7:0]  ps_data = '0;
  logic        busy, done;

  rds_msg_builder_if wr_if ();

  rds_msg_builder #(.c_base_addr(BASE), .c_repeat(R)) u_dut (
    .clk(clk), .reset(reset), .start(start), .pi(pi), .pty(pty), .tp(tp), .ta(ta), .ms(ms),
    .di(di), .ps_we(ps_we), .ps_addr(ps_addr), .ps_data(ps_data), .wr(wr_if),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  cap[NB];
  logic [8:0]  cap_addr[NB];
  logic [63:0] ps_model = "RADIO   ";
  int          checks = 0;
  int          errors = 0;

  function automatic logic [9:0] crc_div(input logic [15:0] d);
    logic [25:0] r;
    r = {d, 10'h000};
    for (int i = 25; i >= 10; i--)
      if (r[i]) r = r ^ (26'h5B9 << (i - 10));
    return r[9:0];
  endfunction

  task automatic push_expected();
    logic [415:0] stream;
    logic [15:0]  d;
    logic [9:0]   off;
    logic [1:0]   s2;
    int           pos;
    wr_t          w;
    pos = 0;
    stream = '0;
    for (int s = 0; s < 4; s++) begin
      s2 = 2'(s);
      for (int b = 0; b < 4; b++) begin
        case (b)
          0: begin d = pi; off = 10'h0FC; end
          1: begin d = {5'b0, tp, pty, ta, ms, di[3 - s], s2}; off = 10'h198; end
          2: begin d = 16'hE0CD; off = 10'h168; end
          default: begin d = ps_model[63 - 16 * s -: 16]; off = 10'h1B4; end
        endcase
        stream[415 - pos -: 26] = {d, crc_div(d) ^ off};
        pos += 26;
      end
    end
    for (int n = 0; n < NB; n++) begin
      w.addr = 9'(int'(BASE) + n);
      w.data = stream[415 - 8 * (n % 52) -: 8];
      exp_q.push_back(w);
    end
  endtask

  task automatic do_start();
    push_expected();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs edges 1.. after a start; pops and compares every RAM write against the scoreboard.
  task automatic run_build(input int inj_at, input int rst_at, output int done_e,
                           output int busy_n, output int nwr, output int first_wr);
    wr_t e_w;
    done_e = -1; busy_n = 0; nwr = 0; first_wr = -1;
    for (int e = 1; e <= 4000; e++) begin
      if (e == inj_at) start = 1'b1;
      if (e == rst_at) reset = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (e == rst_at) break;
      if (wr_if.wr_en) begin
        if (first_wr < 0) first_wr = e;
        if (nwr < NB) begin
          cap[nwr]      = wr_if.wr_data;
          cap_addr[nwr] = wr_if.wr_addr;
        end
        nwr++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_write edge %0d got addr %0d data %h, required no write", e,
                   wr_if.wr_addr, wr_if.wr_data);
        end else begin
          e_w = exp_q.pop_front();
          if (wr_if.wr_addr !== e_w.addr || wr_if.wr_data !== e_w.data) begin
            errors++;
            $display("FAIL sb_write edge %0d got addr %0d data %h, required addr %0d data %h",
                     e, wr_if.wr_addr, wr_if.wr_data, e_w.addr, e_w.data);
          end
        end
      end
      if (busy) busy_n++;
      if (done && done_e < 0) done_e = e;
      if (done_e >= 0 && !busy) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wr_if.wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b required 0", wr_if.wr_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b required 0", done); end
    checks++; if (wr_if.wr_addr !== BASE) begin errors++; $display("FAIL rst_addr got %0d required %0d", wr_if.wr_addr, BASE); end
    checks++; if (wr_if.wr_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h required 00", wr_if.wr_data); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_pi();
    int d_e, b_n, nw, f_w;
    logic ok;
    pi = '0; pty = '0; tp = 0; ta = 0; ms = 0; di = '0;
    do_start();
    run_build(0, 0, d_e, b_n, nw, f_w);
    checks++; if (d_e !== DONE_E) begin errors++; $display("FAIL zp_done_edge got %0d required %0d", d_e, DONE_E); end
    checks++; if (b_n !== DONE_E) begin errors++; $display("FAIL zp_busy_cycles got %0d required %0d", b_n, DONE_E); end
    checks++; if (nw !== NB) begin errors++; $display("FAIL zp_writes got %0d required %0d", nw, NB); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL zp_leftover got %0d required 0", exp_q.size()); end
    checks++; if (f_w !== 25) begin errors++; $display("FAIL zp_first_wr got %0d required 25", f_w); end
    checks++;
    if ({cap[0], cap[1], cap[2], cap[3]} !== 32'h00003F00) begin
      errors++; $display("FAIL zp_bytes0_3 got %h required 00003f00", {cap[0], cap[1], cap[2], cap[3]});
    end
    checks++;
    if ({cap[5][5:0], cap[6][7:4]} !== 10'h198) begin
      errors++; $display("FAIL zp_chk_b got %h required 198", {cap[5][5:0], cap[6][7:4]});
    end
    checks++;
    if ({cap[9][1:0], cap[10], cap[11][7:2]} !== 16'h5241) begin
      errors++; $display("FAIL zp_seg0_d got %h required 5241", {cap[9][1:0], cap[10], cap[11][7:2]});
    end
    checks++;
    if (cap_addr[11] !== 9'd511 || cap_addr[12] !== 9'd0 || cap_addr[NB-1] !== 9'd247) begin
      errors++; $display("FAIL zp_addr_wrap got %0d %0d %0d required 511 0 247",
                         cap_addr[11], cap_addr[12], cap_addr[NB-1]);
    end
    ok = 1'b1;
    for (int n = 0; n + 52 < NB; n++) if (cap[n] !== cap[n + 52]) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL zp_repeat got differing copies required identical"); end
  endtask

  task automatic test_pi_one();
    int d_e, b_n, nw, f_w;
    pi = 16'h0001;
    do_start();
    run_build(0, 0, d_e, b_n, nw, f_w);
    checks++; if (cap[2] !== 8'h51) begin errors++; $display("FAIL pi1_byte2 got %h required 51", cap[2]); end
    checks++; if (cap[3][7:6] !== 2'b01) begin errors++; $display("FAIL pi1_byte3_top got %b required 01", cap[3][7:6]); end
    checks++; if (nw !== NB) begin errors++; $display("FAIL pi1_writes got %0d required %0d", nw, NB); end
  endtask

  task automatic test_start_busy();
    int d_e, b_n, nw, f_w;
    pi = 16'h1234; pty = 5'h0A; tp = 1; ta = 0; ms = 1; di = 4'b1010;
    do_start();
    run_build(100, 0, d_e, b_n, nw, f_w);
    checks++; if (nw !== NB) begin errors++; $display("FAIL sb_ign_writes got %0d required %0d", nw, NB); end
    checks++; if (d_e !== DONE_E) begin errors++; $display("FAIL sb_ign_done got %0d required %0d", d_e, DONE_E); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_ign_leftover got %0d required 0", exp_q.size()); end
  endtask

  // Called straight after a build returns, i.e. in the cycle busy has just fallen.
  task automatic test_back_to_back();
    int d_e, b_n, nw, f_w;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_fell got %b required 0", busy); end
    pi = 16'hBEEF; pty = 5'h1F; tp = 0; ta = 1; ms = 0; di = 4'b0110;
    do_start();
    run_build(0, 0, d_e, b_n, nw, f_w);
    checks++; if (nw !== NB) begin errors++; $display("FAIL b2b_writes got %0d required %0d", nw, NB); end
    checks++; if (d_e !== DONE_E) begin errors++; $display("FAIL b2b_done got %0d required %0d", d_e, DONE_E); end
  endtask

  task automatic test_reset_mid();
    int d_e, b_n, nw, f_w;
    logic seen;
    pi = 16'hC0DE; pty = 5'h03; tp = 1; ta = 1; ms = 1; di = 4'b1111;
    do_start();
    run_build(0, 300, d_e, b_n, nw, f_w);
    checks++; if (wr_if.wr_en !== 1'b0) begin errors++; $display("FAIL rm_wr_en got %b required 0", wr_if.wr_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b required 0", busy); end
    checks++; if (wr_if.wr_addr !== BASE) begin errors++; $display("FAIL rm_addr got %0d required %0d", wr_if.wr_addr, BASE); end
    exp_q.delete();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy || wr_if.wr_en) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rm_quiet got activity required none"); end
    do_start();
    run_build(0, 0, d_e, b_n, nw, f_w);
    checks++; if (nw !== NB) begin errors++; $display("FAIL rm_rebuild_writes got %0d required %0d", nw, NB); end
    checks++; if (cap_addr[0] !== BASE) begin errors++; $display("FAIL rm_rebuild_addr0 got %0d required %0d", cap_addr[0], BASE); end
  endtask

`ifdef RDS_PS_WRITE_EN
  task automatic test_ps_write();
    int d_e, b_n, nw, f_w;
    logic [63:0] s;
    s = "ABCDEFGH";
    for (int i = 0; i < 8; i++) begin
      ps_we = 1'b1; ps_addr = 3'(i); ps_data = s[63 - 8 * i -: 8];
      @(posedge clk); #1;
    end
    ps_we = 1'b0;
    ps_model = s;
    pi = 16'h0000; pty = '0; tp = 0; ta = 0; ms = 0; di = '0;
    do_start();
    ps_we = 1'b1; ps_addr = 3'd0; ps_data = 8'h7A;
    run_build(0, 0, d_e, b_n, nw, f_w);
    ps_we = 1'b0;
    checks++;
    if ({cap[22][1:0], cap[23], cap[24][7:2]} !== 16'h4344) begin
      errors++; $display("FAIL ps_seg1_d got %h required 4344", {cap[22][1:0], cap[23], cap[24][7:2]});
    end
    do_start();
    run_build(0, 0, d_e, b_n, nw, f_w);
    checks++;
    if ({cap[9][1:0], cap[10], cap[11][7:2]} !== 16'h4142) begin
      errors++; $display("FAIL ps_busy_ignored got %h required 4142", {cap[9][1:0], cap[10], cap[11][7:2]});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_pi();
    test_pi_one();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef RDS_PS_WRITE_EN
    test_ps_write();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
